// File: rtl/mole_hit_judge.sv
`default_nettype none
// ============================================================================
//  Module   : mole_hit_judge
//  Purpose  : Scoring stage for a whack-a-mole game. Compares one-cycle button
//             press pulses against the mole-up mask. It produces registered
//             hit/miss/whack pulses, applies a lockout penalty after a miss,
//             tracks a saturating combo streak and keeps a saturating 4-digit
//             packed BCD score.
//  Ports    : clk, rst (async, active-high)
//             game_active       - round-running level from the game controller
//             btn_pulse[N]      - one-cycle press pulses, one bit per hole
//             mole_mask[N]      - moles currently up
//             whack[N]          - one-cycle pulse per hole hit (lowers mole)
//             hit / miss        - one-cycle event pulses
//             locked            - high while in the miss lockout
//             combo[7:0]        - consecutive-hit streak, saturates at 255
//             score[15:0]       - packed BCD score, saturates at 9999
//  Revision : 1.0 - initial release
// ============================================================================
module mole_hit_judge #(
    parameter int N_HOLES        = 8,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter int COMBO_THRESH   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_active,
    input  logic [N_HOLES-1:0] btn_pulse,
    input  logic [N_HOLES-1:0] mole_mask,
    output logic [N_HOLES-1:0] whack,
    output logic               hit,
    output logic               miss,
    output logic               locked,
    output logic [7:0]         combo,
    output logic [15:0]        score
);

    // Counter holds LOCKOUT_CYCLES-1 down to 0; keep at least one bit.
    localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ga_q, ga_d;
    logic [15:0]        score_q, score_d;
    logic [7:0]         combo_q, combo_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               locked_q, locked_d;
    logic [N_HOLES-1:0] whack_q, whack_d;
    logic [N_HOLES-1:0] hit_vec;
    logic [N_HOLES-1:0] miss_vec;
    logic [1:0]         points;

    // Adds 1 or 2 to a valid packed-BCD value with per-digit decimal carry.
    // A carry out of the thousands digit clamps the result to 9999.
    function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [1:0] p);
        logic [15:0] r;
        logic [4:0]  d;
        logic [1:0]  c;
        r = '0;
        c = p;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {3'b000, c};
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                c           = 2'd1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                c           = 2'd0;
            end
        end
        if (c != 2'd0) begin
            r = 16'h9999;
        end
        return r;
    endfunction

    assign hit_vec  = btn_pulse & mole_mask;
    assign miss_vec = btn_pulse & ~mole_mask;
    // Bonus is decided on the streak before this hit is counted.
    assign points   = (int'(combo_q) >= COMBO_THRESH) ? 2'd2 : 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ga_d    = game_active;
        score_d = score_q;
        combo_d = combo_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        whack_d = '0;

        case (state_q)
            S_IDLE: begin
                // Only a fresh rising edge starts a round; presses are ignored.
                if (game_active && !ga_q) begin
                    score_d = '0;
                    combo_d = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (!game_active) begin
                    state_d = S_IDLE;
                end else if (miss_vec != '0) begin
                    // A wrong hole anywhere overrides any correct presses.
                    miss_d  = 1'b1;
                    combo_d = '0;
                    cnt_d   = C_LOCK_LOAD;
                    state_d = S_LOCKOUT;
                end else if (hit_vec != '0) begin
                    hit_d   = 1'b1;
                    whack_d = hit_vec;
                    score_d = bcd_add(score_q, points);
                    combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
                end
            end
            S_LOCKOUT: begin
                if (!game_active) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        locked_d = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ga_q     <= 1'b0;
            score_q  <= '0;
            combo_q  <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            locked_q <= 1'b0;
            whack_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ga_q     <= ga_d;
            score_q  <= score_d;
            combo_q  <= combo_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            whack_q  <= whack_d;
        end
    end

    assign whack  = whack_q;
    assign hit    = hit_q;
    assign miss   = miss_q;
    assign locked = locked_q;
    assign combo  = combo_q;
    assign score  = score_q;

endmodule
`default_nettype wire

// File: doc/mole_hit_judge.md
# mole_hit_judge

Scoring stage that sits directly downstream of the per-hole button debounce/edge blocks. It consumes their one-cycle press pulses and compares them with the mole-up mask from the mole generator. It issues registered hit, miss and whack pulses, applies a miss lockout penalty, tracks a combo streak, and keeps a saturating BCD score for the display driver.

## Interface
- N_HOLES, 8, number of holes; width of the button and mole vectors
- LOCKOUT_CYCLES, 50_000_000, cycles during which buttons are ignored after a miss (must be ≥1)
- COMBO_THRESH, 5, streak length at which each hit scores 2 instead of 1
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- game_active  input  1  level from game controller; high while a round runs
- btn_pulse  input  N_HOLES  one-cycle press pulses from the debounce stage, one bit per hole
- mole_mask  input  N_HOLES  moles currently up, one bit per hole
- whack  output  N_HOLES  one-cycle pulse per hole hit, sent to the mole generator to lower the mole
- hit  output  1  one-cycle pulse on a scoring cycle
- miss  output  1  one-cycle pulse on a penalty cycle
- locked  output  1  high while in LOCKOUT
- combo  output  8  current consecutive-hit streak, saturates at 255
- score  output  16  4-digit packed BCD; [15:12] is the thousands digit

## Operation
- FSM states: IDLE, PLAY, LOCKOUT. Reset state is IDLE.
- Reset values: all outputs 0; lockout counter 0; game_active edge register 0.
- IDLE:
  - Buttons are ignored.
  - score and combo hold their values.
  - A rising edge of game_active (current 1, previous 0) clears score and combo to 0 and moves to PLAY.
- PLAY: per cycle, compute the masked hit and miss vectors:
  - H = btn_pulse & mole_mask
  - M = btn_pulse & ~mole_mask
  - If M ≠ 0, it is a miss cycle:
    - miss=1, hit=0, whack=0, combo←0, no score change.
    - Lockout counter loads LOCKOUT_CYCLES-1; state moves to LOCKOUT.
    - A miss wins over any simultaneous hits.
  - Else if H ≠ 0, it is a hit cycle:
    - hit=1, whack=H.
    - Points P=2 if the pre-update combo ≥ COMBO_THRESH, else P=1.
    - score←score+P in BCD; combo←combo+1, saturating at 255.
    - A cycle counts as one hit regardless of popcount(H).
  - Else: no event.
- LOCKOUT:
  - locked=1 and btn_pulse is ignored.
  - The counter decrements each cycle; when it reaches 0, the state returns to PLAY on the next cycle.
- game_active low in PLAY or LOCKOUT moves to IDLE on the next cycle.
  - Lockout is aborted and locked drops.
  - score and combo are held.
- Input priority each cycle: game_active low, then miss, then hit.
- BCD arithmetic:
  - Per-digit add with decimal carry.
  - Any result above 9999 saturates to 16'h9999.
  - No digit ever holds a value above 9.

## Timing
- Inputs are sampled at edge t. hit, miss, whack, score, combo and locked update at edge t+1, giving 1-cycle latency.
- hit, miss and whack are high for exactly one cycle per event.
- Miss at edge t:
  - locked=1 from t+1 through t+LOCKOUT_CYCLES inclusive.
  - The first press that can be accepted is sampled at edge t+LOCKOUT_CYCLES+1.
- Presses in the same cycle the miss is registered are already covered by the miss rule. Presses during lockout are dropped, not queued.
- game_active rising edge: score and combo read 0 at t+1. A press in that same cycle is ignored because the state is still IDLE.
- Async rst mid-lockout or mid-round: everything returns immediately to the reset values.

## Test plan
- **Basic hit.** Reset, game_active↑, mole_mask=8'h04, btn_pulse=8'h04 for 1 cycle → next cycle hit=1, whack=8'h04, score=16'h0001, combo=1.
- **Miss precedence and lockout** (LOCKOUT_CYCLES=4). mole_mask=8'h01, btn_pulse=8'h03 → miss=1, whack=0, combo=0, score unchanged. locked=1 for exactly 4 cycles. A press during lockout produces nothing; a press on the 5th cycle after the miss scores.
- **Combo bonus** (COMBO_THRESH=5). Apply 7 separate hit cycles from score 0 → scores 1,2,3,4,5,7,9 and combo=7.
- **BCD carry and saturation.**
  - Preload by hits to 16'h0099, then one hit → 16'h0100.
  - At 16'h9998 with P=2 → 16'h9999; a further hit stays at 16'h9999.
- **Multi-hole hit.** mole_mask=8'hF0, btn_pulse=8'h30 → whack=8'h30, score +1 (not +2), combo +1.
- **Round control and reset.**
  - game_active↓ during lockout → IDLE, locked=0 next cycle, presses ignored, score held.
  - game_active↑ → score=0, combo=0.
  - Async rst asserted mid-cycle → all outputs 0 immediately.
